// File: rtl/conv_output_collect_pkg.sv
// Shared convolution constants, column-range tables and accumulator helpers
// used by the output collector and its emit sequencer.
package conv_output_collect_pkg;

   localparam int CONVUNITS     = 1;
   localparam int CONV_SIZE_MAX = 32;
   localparam int CONV_BITS     = 8;
   localparam int ACC_BITS      = 12;
   localparam int MAX_GROUPS    = 8;

   typedef logic signed [ACC_BITS-1:0] acc_t;
   typedef logic [4:0]                 col_t;
   typedef enum logic {ACCUM, EMIT}    collect_state_e;

   // Index 3 of the parallelism dimension is illegal; it holds a harmless single range.
   localparam logic [2:0] PARALLEL_NUM [CONVUNITS][4] = '{'{3'd1, 3'd2, 3'd6, 3'd1}};

   localparam col_t PARALLEL_OUT [CONVUNITS][4][MAX_GROUPS][2] = '{
      '{
         '{'{5'd0, 5'd27}, '{5'd0, 5'd0}, '{5'd0, 5'd0}, '{5'd0, 5'd0},
           '{5'd0, 5'd0},  '{5'd0, 5'd0}, '{5'd0, 5'd0}, '{5'd0, 5'd0}},
         '{'{5'd0, 5'd9},  '{5'd14, 5'd23}, '{5'd0, 5'd0}, '{5'd0, 5'd0},
           '{5'd0, 5'd0},  '{5'd0, 5'd0},   '{5'd0, 5'd0}, '{5'd0, 5'd0}},
         '{'{5'd0, 5'd0},  '{5'd6, 5'd6},   '{5'd12, 5'd12}, '{5'd18, 5'd18},
           '{5'd24, 5'd24}, '{5'd30, 5'd30}, '{5'd0, 5'd0},  '{5'd0, 5'd0}},
         '{'{5'd0, 5'd0},  '{5'd0, 5'd0}, '{5'd0, 5'd0}, '{5'd0, 5'd0},
           '{5'd0, 5'd0},  '{5'd0, 5'd0}, '{5'd0, 5'd0}, '{5'd0, 5'd0}}
      }
   };

   function automatic acc_t sat_add(input acc_t a, input logic signed [CONV_BITS-1:0] b);
      logic signed [ACC_BITS:0] s;
      s = $signed({a[ACC_BITS-1], a}) + (ACC_BITS+1)'(b);
      if (s[ACC_BITS] != s[ACC_BITS-1])
         sat_add = s[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
      else
         sat_add = s[ACC_BITS-1:0];
   endfunction

endpackage

// File: rtl/conv_output_sequencer.sv
// Walks the valid output columns group by group for the latched parallelism
// and flags the final pixel of the row.
module conv_output_sequencer
   import conv_output_collect_pkg::*;
#(
   parameter int UNIT = 0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       advance_i,
   input  logic [1:0] par_i,
   output logic [2:0] grp_o,
   output logic [4:0] col_o,
   output logic       last_o
);

   logic [2:0] grp_q, grp_d;
   col_t       col_q, col_d;
   col_t       hi;

   assign hi     = PARALLEL_OUT[UNIT][par_i][grp_q][1];
   assign last_o = (grp_q == PARALLEL_NUM[UNIT][par_i] - 3'd1) && (col_q == hi);
   assign grp_o  = grp_q;
   assign col_o  = col_q;

   always_comb begin
      grp_d = grp_q;
      col_d = col_q;
      if (start_i) begin
         grp_d = '0;
         col_d = PARALLEL_OUT[UNIT][par_i][0][0];
      end else if (advance_i) begin
         // After the final pixel park at 0/0 so idle outputs match reset.
         if (last_o) begin
            grp_d = '0;
            col_d = '0;
         end else if (col_q < hi) begin
            col_d = col_q + 5'd1;
         end else begin
            grp_d = grp_q + 3'd1;
            col_d = PARALLEL_OUT[UNIT][par_i][grp_q + 3'd1][0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grp_q <= '0;
         col_q <= '0;
      end else begin
         grp_q <= grp_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/conv_output_collect.sv
// Accumulates convolution rows across input-channel passes with saturation,
// then streams the valid columns of each parallel group downstream.
module conv_output_collect
   import conv_output_collect_pkg::*;
#(
   parameter int UNIT     = 0,
   parameter int ACC_BITS = 12
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [1:0]                        conf_parallel_i,
   input  logic                              conv_valid_i,
   output logic                              conv_ready_o,
   input  logic [CONV_SIZE_MAX*CONV_BITS-1:0] conv_data_i,
   input  logic                              conv_last_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [ACC_BITS-1:0]               out_data_o,
   output logic [2:0]                        out_group_o,
   output logic [4:0]                        out_col_o,
   output logic                              out_last_o
);

   typedef logic signed [ACC_BITS-1:0] sacc_t;

   collect_state_e              state_q;
   logic                        first_q;
   logic [1:0]                  par_q, par_eff;
   sacc_t                       acc_q [CONV_SIZE_MAX];
   sacc_t                       acc_d [CONV_SIZE_MAX];
   logic signed [CONV_BITS-1:0] col_v [CONV_SIZE_MAX];
   logic                        accept, xfer, done, seq_last;
   logic [2:0]                  grp;
   logic [4:0]                  col;

   function automatic sacc_t sat_acc(input sacc_t a, input logic signed [CONV_BITS-1:0] b);
      logic signed [ACC_BITS:0] s;
      s = $signed({a[ACC_BITS-1], a}) + (ACC_BITS+1)'(b);
      if (s[ACC_BITS] != s[ACC_BITS-1])
         sat_acc = s[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
      else
         sat_acc = s[ACC_BITS-1:0];
   endfunction

   for (genvar c = 0; c < CONV_SIZE_MAX; c++) begin : g_col
      assign col_v[c] = conv_data_i[c*CONV_BITS +: CONV_BITS];
   end

   assign conv_ready_o = (state_q == ACCUM);
   assign out_valid_o  = (state_q == EMIT);
   assign accept       = conv_valid_i && conv_ready_o;
   assign xfer         = out_valid_o && out_ready_i;
   assign done         = xfer && seq_last;
   // The parallelism of a row is fixed by its first pass.
   assign par_eff      = first_q ? conf_parallel_i : par_q;

   always_comb begin
      acc_d = acc_q;
      for (int c = 0; c < CONV_SIZE_MAX; c++) begin
         if (done)
            acc_d[c] = '0;
         else if (accept)
            acc_d[c] = first_q ? sacc_t'(col_v[c]) : sat_acc(acc_q[c], col_v[c]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ACCUM;
         first_q <= 1'b1;
         par_q   <= '0;
         acc_q   <= '{default: '0};
      end else begin
         acc_q <= acc_d;
         case (state_q)
            ACCUM: if (accept) begin
               if (first_q) begin
                  par_q   <= conf_parallel_i;
                  first_q <= 1'b0;
               end
               if (conv_last_i) state_q <= EMIT;
            end
            EMIT: if (done) begin
               state_q <= ACCUM;
               first_q <= 1'b1;
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   conv_output_sequencer #(.UNIT(UNIT)) u_seq (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (accept && conv_last_i),
      .advance_i (xfer),
      .par_i     (par_eff),
      .grp_o     (grp),
      .col_o     (col),
      .last_o    (seq_last)
   );

   assign out_data_o  = acc_q[col];
   assign out_group_o = grp;
   assign out_col_o   = col;
   assign out_last_o  = out_valid_o && seq_last;

   a_par_legal: assert property (@(posedge clk_i) disable iff (rst_i)
      (accept && first_q) |-> (conf_parallel_i != 2'd3));

endmodule

// File: doc/conv_output_collect.md
Name: conv_output_collect

Overview:
- Sits directly downstream of one convolution unit.
- Each beat it takes one full output row of CONV_SIZE_MAX signed partial sums and accumulates rows across input-channel passes with saturation.
- After the last pass it serialises only the valid output columns of each parallel group, using the pkg_convolution PARALLEL_OUT ranges, to the activation writer over a valid/ready stream.
- One instance per convolution unit.

Parameters:
- UNIT, 0: convolution unit index into the pkg_convolution arrays; must be < CONVUNITS.
- ACC_BITS, 12: accumulator width in bits; must be ≥ CONV_BITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- conf_parallel  in  2  parallelism index 0..2 into PARALLEL_NUM[UNIT]; sampled on the first accepted pass of a row.
- conv_valid  in  1  row beat valid.
- conv_ready  out  1  block accepts a row beat.
- conv_data  in  CONV_SIZE_MAX*CONV_BITS  packed row; column c occupies bits [c*CONV_BITS +: CONV_BITS]; each value is signed two's complement.
- conv_last  in  1  marks the final accumulation pass of this row.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts.
- out_data  out  ACC_BITS  accumulated signed pixel.
- out_group  out  3  parallel group index g.
- out_col  out  5  absolute column index c.
- out_last  out  1  high on the final pixel of the row.

Behaviour:
- Clocking: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State is ACCUM and the accumulator array is all 0.
  - first_pass is 1 and the latched parallelism index is 0.
  - conv_ready=1, out_valid=0, out_data=0, out_group=0, out_col=0, out_last=0.
- Reset mid-operation: any partial row, in either state, is discarded with no output.
- ACCUM state:
  - conv_ready=1 and out_valid=0.
  - A beat is accepted when conv_valid and conv_ready are both high.
  - If first_pass=1: acc[c] = sign_extend(conv_data[c]), par = conf_parallel, first_pass is cleared.
  - Otherwise: acc[c] = sat(acc[c] + sign_extend(conv_data[c])).
  - sat clamps to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1].
  - Accepting a beat with conv_last=1 moves to EMIT on the next cycle, with g=0 and c=PARALLEL_OUT[UNIT][par][0][0].
- EMIT state:
  - conv_ready=0.
  - out_valid=1 with out_data=acc[c], out_group=g, out_col=c.
  - out_last=1 iff g=PARALLEL_NUM[UNIT][par]-1 and c=PARALLEL_OUT[UNIT][par][g][1].
  - On out_valid && out_ready: if c < PARALLEL_OUT[..][g][1], increment c; otherwise increment g and load c with that group's start column.
  - The transfer with out_last=1 clears acc and sets first_pass=1, then returns to ACCUM.
  - One pixel per cycle under continuous ready.
  - With out_ready=0, out_data, out_group and out_col are held stable.
- Latency: the first output pixel is valid 1 cycle after the last-pass beat is accepted.
- Throughput: ACCUM re-accepts input the cycle after the out_last transfer; there is no overlap between rows (single-buffered).
- A single-pass row (first beat carries conv_last=1) loads the accumulator and emits without any add.
- Changes on conf_parallel between passes of the same row are ignored.
- Columns outside every PARALLEL_OUT range are never emitted.
- Pixel counts per row for UNIT=0:
  - par=0: 28 pixels (c 0..27).
  - par=1: 20 pixels (0..9, 14..23).
  - par=2: 6 pixels (0, 6, 12, 18, 24, 30).
- conf_parallel=3 is illegal; the assertion fires in simulation.

Decomposition:
- Add to pkg_convolution:
  - ACC_BITS;
  - typedef acc_t (signed ACC_BITS);
  - typedef enum collect_state_e {ACCUM, EMIT};
  - function sat_add(acc_t, logic signed [CONV_BITS-1:0]) returning acc_t.
- Emit-order control is natural as one sub-module, conv_output_sequencer. It holds the g/c counters, the range lookup and last detection, and exposes an advance input plus g/c/last outputs.

Test Plan:
- par=0, one pass with conv_last=1, column c value = c, out_ready=1 -> 28 pixels, out_data 0..27 in order, out_last only on c=27, first pixel 1 cycle after the beat.
- par=1, three passes each with all columns = 5 -> 20 pixels, each out_data=15; order is g=0 c=0..9, then g=1 c=14..23; conv_ready=0 throughout emission.
- par=2, two passes of +100 at every column, ACC_BITS=8 -> every out_data saturates to 127; a repeat with -100 gives -128; cols 0, 6, 12, 18, 24, 30.
- par=0 with out_ready toggling 1010... -> outputs held stable while stalled, no pixel dropped or duplicated, 28 transfers total.
- conf_parallel changed from 2 to 0 on the second pass -> emission still follows par=2 (6 pixels).
- rst asserted during EMIT after 3 pixels -> out_valid=0 and conv_ready=1 the next cycle; the next single-pass row of value 1 emits 1, not an accumulated 2.
